// File: rtl/kernel_bc_start_arbiter_pkg.sv
// Shared types and constants for the kernel start/data FIFO arbiter.
package kernel_bc_start_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int BURST_W = 4;

  // A single requester still needs a 1-bit index so port widths never collapse to zero.
  function automatic int grant_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kernel_bc_rr_pick.sv
// Round-robin search: first set request strictly after 'last', wrapping around.
module kernel_bc_rr_pick
  import kernel_bc_start_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = grant_idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand     = (int'(last) + k) % NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (req[cand_idx]) begin
        found = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/kernel_bc_start_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters bursts of up to MAX_BURST
// beats on one shared FIFO write port.
module kernel_bc_start_arbiter
  import kernel_bc_start_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                fifo_full_n,
  output logic                                fifo_write,
  output logic                                fifo_write_ce,
  output logic [DATA_WIDTH-1:0]               fifo_din,
  output logic                                grant_valid,
  output logic [grant_idx_width(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = grant_idx_width(NUM_REQ);

  state_t             state;
  logic [BURST_W-1:0] burst_cnt;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               owner_valid;
  logic               beat;

  kernel_bc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .found (pick_found),
    .index (pick_idx)
  );

  // Reset gates the handshake combinationally so a mid-burst reset never writes.
  assign owner_valid   = req_valid[grant_id];
  assign beat          = reset_n && (state == GRANT) && owner_valid && fifo_full_n;
  assign fifo_write    = beat;
  assign fifo_write_ce = 1'b1;

  always_comb begin
    req_ready           = '0;
    req_ready[grant_id] = beat;
    fifo_din            = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDX_W'(i)) fifo_din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      grant_id    <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id    <= pick_idx;
            burst_cnt   <= '0;
            state       <= GRANT;
            grant_valid <= 1'b1;
          end
        end
        GRANT: begin
          // A released owner or a completed burst both hand priority onward.
          if (!owner_valid) begin
            last_grant  <= grant_id;
            state       <= IDLE;
            grant_valid <= 1'b0;
          end else if (beat) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == BURST_W'(MAX_BURST - 1)) begin
              last_grant  <= grant_id;
              state       <= IDLE;
              grant_valid <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_bc_start_arbiter.sv
// Scoreboard bench for kernel_bc_start_arbiter: directed scenarios plus a long random run.
module tb_kernel_bc_start_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full_n;
  logic            fifo_write;
  logic            fifo_write_ce;
  logic [DW-1:0]   fifo_din;
  logic            grant_valid;
  logic [IW-1:0]   grant_id;

  always #5 clk = ~clk;

  kernel_bc_start_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full_n   (fifo_full_n),
    .fifo_write    (fifo_write),
    .fifo_write_ce (fifo_write_ce),
    .fifo_din      (fifo_din),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id)
  );

  typedef struct packed {
    logic          wr;
    logic [N-1:0]  rdy;
    logic [DW-1:0] din;
    logic          gv;
    logic [IW-1:0] gid;
  } exp_t;

  logic [DW-1:0] tok [N];
  logic [DW-1:0] exp_next [N];
  int            wait_rounds [N];
  exp_t          sb [$];
  int            grant_log [$];
  int            grant_cyc [$];
  logic [DW-1:0] wr_din [$];
  int            wr_gid [$];
  logic [N-1:0]  accepted;
  logic          prev_gv;
  int            cyc;
  int            errors;
  int            checks;

  bit m_gr;
  int m_gid;
  int m_last;
  int m_cnt;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = tok[i];
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive, predict, sample mid-cycle, then advance the reference model.
  task automatic applyStimulus(input logic rst_in, input logic [N-1:0] v, input logic full_in);
    exp_t e;
    exp_t got;
    logic beat;
    bit   found;
    int   c;
    @(negedge clk);
    for (int i = 0; i < N; i++) if (accepted[i]) tok[i] = tok[i] + 1;
    reset_n     = rst_in;
    req_valid   = v;
    fifo_full_n = full_in;

    beat  = rst_in && m_gr && v[m_gid] && full_in;
    e.wr  = beat;
    e.rdy = beat ? (N'(1) << m_gid) : '0;
    e.din = tok[m_gid];
    e.gv  = m_gr;
    e.gid = IW'(m_gid);
    sb.push_back(e);

    #1;
    got = sb.pop_front();
    checkOutput("fifo_write", fifo_write, got.wr);
    checkOutput("req_ready", req_ready, got.rdy);
    checkOutput("grant_valid", grant_valid, got.gv);
    checkOutput("grant_id", grant_id, got.gid);
    checkOutput("write_ce", fifo_write_ce, 1);
    if (got.wr) checkOutput("fifo_din", fifo_din, got.din);
    checkOutput("write_while_full", fifo_write && !fifo_full_n, 0);
    checkOutput("ready_onehot0", $onehot0(req_ready), 1);
    if (fifo_write) begin
      checkOutput("data_order", fifo_din, exp_next[grant_id]);
      exp_next[grant_id] = exp_next[grant_id] + 1;
      wr_din.push_back(fifo_din);
      wr_gid.push_back(int'(grant_id));
    end
    if (grant_valid && !prev_gv) begin
      grant_log.push_back(int'(grant_id));
      grant_cyc.push_back(cyc);
    end
    prev_gv  = grant_valid;
    accepted = req_ready;
    cyc++;

    for (int i = 0; i < N; i++) if (!v[i]) wait_rounds[i] = 0;
    if (!rst_in) begin
      m_gr = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
      for (int i = 0; i < N; i++) wait_rounds[i] = 0;
    end else if (!m_gr) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && v[c]) begin
          found = 1; m_gr = 1; m_gid = c; m_cnt = 0;
        end
      end
      if (found) begin
        for (int i = 0; i < N; i++) begin
          if (i == m_gid) begin
            checkOutput("starvation", wait_rounds[i] < N, 1);
            wait_rounds[i] = 0;
          end else if (v[i]) begin
            wait_rounds[i]++;
          end
        end
      end
    end else if (!v[m_gid]) begin
      m_gr = 0; m_last = m_gid;
    end else if (beat) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_gr = 0; m_last = m_gid;
      end
    end
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rst_grant_valid", grant_valid, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    grant_log.delete();
    grant_cyc.delete();
    wr_din.delete();
    wr_gid.delete();
  endtask

  initial begin
    int exp_ids [5];
    logic [N-1:0] rv;
    errors = 0; checks = 0; cyc = 0;
    m_gr = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
    prev_gv = 0; accepted = '0;
    for (int i = 0; i < N; i++) begin
      tok[i]         = (DW'(i) << 24) | 32'h10;
      exp_next[i]    = tok[i];
      wait_rounds[i] = 0;
    end
    reset_n = 1'b0; req_valid = '0; fifo_full_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single requester 0: one-cycle latency, then four beats 0x10..0x13.
    resetDut();
    applyStimulus(1'b1, 4'b0001, 1'b1);
    checkOutput("t1_idle_gv", grant_valid, 0);
    applyStimulus(1'b1, 4'b0001, 1'b1);
    checkOutput("t1_gv", grant_valid, 1);
    checkOutput("t1_gid", grant_id, 0);
    repeat (3) applyStimulus(1'b1, 4'b0001, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("t1_back_idle", grant_valid, 0);
    checkOutput("t1_nwrites", wr_din.size(), 4);
    for (int k = 0; k < 4 && k < wr_din.size(); k++)
      checkOutput($sformatf("t1_din%0d", k), wr_din[k], 32'h10 + k);

    // All requesters busy: rotation 0,1,2,3,0 with four writes each and one idle gap.
    resetDut();
    repeat (25) applyStimulus(1'b1, 4'b1111, 1'b1);
    exp_ids = '{0, 1, 2, 3, 0};
    checkOutput("t2_ngrants", grant_log.size(), 5);
    checkOutput("t2_nwrites", wr_gid.size(), 20);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      checkOutput($sformatf("t2_grant%0d", k), grant_log[k], exp_ids[k]);
    for (int k = 1; k < grant_cyc.size(); k++)
      checkOutput($sformatf("t2_spacing%0d", k), grant_cyc[k] - grant_cyc[k-1], 5);
    for (int k = 0; k < 20 && k < wr_gid.size(); k++)
      checkOutput($sformatf("t2_wgid%0d", k), wr_gid[k], exp_ids[k/4]);

    // Requester 2 stalled by a full FIFO for three cycles after its first beat.
    resetDut();
    applyStimulus(1'b1, 4'b0100, 1'b1);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("t3_beat1", fifo_write, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 4'b0100, 1'b0);
      checkOutput("t3_stall_wr", fifo_write, 0);
      checkOutput("t3_stall_rdy", req_ready, 0);
      checkOutput("t3_stall_gv", grant_valid, 1);
    end
    repeat (3) applyStimulus(1'b1, 4'b0100, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("t3_back_idle", grant_valid, 0);
    checkOutput("t3_nwrites", wr_gid.size(), 4);
    for (int k = 0; k < wr_gid.size(); k++) checkOutput("t3_wgid", wr_gid[k], 2);

    // Requester 1 releases after two beats; the next pick starts after it.
    resetDut();
    applyStimulus(1'b1, 4'b0010, 1'b1);
    repeat (2) applyStimulus(1'b1, 4'b0010, 1'b1);
    applyStimulus(1'b1, 4'b1001, 1'b1);
    checkOutput("t4_release_wr", fifo_write, 0);
    applyStimulus(1'b1, 4'b1011, 1'b1);
    checkOutput("t4_idle_gv", grant_valid, 0);
    applyStimulus(1'b1, 4'b1011, 1'b1);
    checkOutput("t4_gv", grant_valid, 1);
    checkOutput("t4_gid", grant_id, 3);
    checkOutput("t4_nwrites_before", wr_gid.size() >= 2 ? wr_gid[1] : -1, 1);

    // Reset in the middle of a burst suppresses the write in that same cycle.
    resetDut();
    applyStimulus(1'b1, 4'b1111, 1'b1);
    repeat (2) applyStimulus(1'b1, 4'b1111, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("t5_rst_wr", fifo_write, 0);
    checkOutput("t5_rst_rdy", req_ready, 0);
    checkOutput("t5_rst_ce", fifo_write_ce, 1);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("t5_idle_gv", grant_valid, 0);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("t5_gv", grant_valid, 1);
    checkOutput("t5_gid", grant_id, 0);
    repeat (4) applyStimulus(1'b1, 4'b0000, 1'b1);

    // Random traffic with sticky valids and a frequently full FIFO.
    resetDut();
    rv = '0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) rv[i] = ~rv[i];
      applyStimulus(1'b1, rv, $urandom_range(3) != 0);
    end
    for (int i = 0; i < N; i++) checkOutput("final_wait", wait_rounds[i] < N, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
